leds_ctrl_pwm: RTL and testbench
================================

// Module: leds_ctrl_pwm
// PURPOSE
//  Parametrised LED peripheral: memory-mapped register bank driving N_LEDS outputs.
//  Per-LED on/off, per-LED blink enable with programmable period, global PWM dimming.
//  Sits on the processor data bus next to the other peripherals; leds_o drives board pins.
// PARAMETERS
//  N_LEDS     16  number of LED channels (1..32)
//  BLINK_W    24  width of blink period register/counter (clk cycles per half-period)
//  PWM_BITS   8   PWM counter/duty width
// PORTS
//  clk_i      in   1         system clock (10 MHz)
//  rst        in   1         reset, synchronous, active-low
//  addr_i     in   2         register select (word index)
//  we_i       in   1         write strobe, active-high, one write per cycle
//  data_i     in   32        write data
//  rdata_o    out  32        read data for addr_i, registered
//  leds_o     out  N_LEDS    LED drive, registered
// BEHAVIOUR
//  Reset (rst==0 at clk_i edge): DATA=0, MODE=0, PERIOD=0, DUTY=all-ones,
//   blink counter=0, blink phase=0, PWM counter=0, rdata_o=0, leds_o=0. Reset wins over we_i.
//  Register map: 0 DATA[N_LEDS-1:0] on/off; 1 MODE[N_LEDS-1:0] 1=blink; 2 PERIOD[BLINK_W-1:0];
//   3 DUTY[PWM_BITS-1:0]. Upper data_i bits ignored; unused read bits return 0.
//  Write: on we_i=1, selected register updated at the edge; effect visible in leds_o next cycle.
//  Read: rdata_o <= reg[addr_i] every cycle (1-cycle latency, independent of we_i);
//   read-during-write to same address returns the OLD value.
//  Blink: counter increments each cycle; when counter==PERIOD-1 -> counter=0, phase toggles.
//   PERIOD==0: counter held 0, phase forced 1 (blink LEDs appear steady on).
//   Any write to PERIOD clears counter and phase in the same edge.
//  PWM: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0.
//   pwm_on = (cnt < DUTY) | (DUTY == all-ones); DUTY==0 -> always off.
//  Output: leds_o[i] <= DATA[i] & (MODE[i] ? phase : 1) & pwm_on.
//  Simultaneous write and phase toggle: both take effect at the same edge; output reflects
//   new register and new phase one cycle later. No other interactions.
// CONFIGURATION
//  Macro LEDS_PWM_EN.
//  Defined: PWM counter and DUTY register present as above.
//  Not defined: no PWM logic; pwm_on tied 1; writes to addr 3 ignored; reads of addr 3 return 0.
// STRUCTURE
//  Package leds_pkg: register address constants (LED_ADDR_DATA..LED_ADDR_DUTY),
//   typedef enum logic {LED_STATIC, LED_BLINK} led_mode_e, default reset constants.
//  Sub-module led_pwm_gen (clk_i, rst, duty_i -> pwm_on_o), instantiated only under LEDS_PWM_EN.
//  Top holds register bank, blink counter/phase, read mux and output register.
// TESTING
//  Reset: hold rst=0 two cycles with we_i=1, data_i=FFFF -> leds_o=0, all reads 0 except DUTY=FF.
//  Static: write DATA=A5A5, MODE=0 -> leds_o=A5A5 from the 2nd edge after the write strobe.
//  Blink: DATA=000F, MODE=0003, PERIOD=4 -> bits1:0 toggle every 4 cycles, bits3:2 steady 1.
//  PERIOD=0 with MODE=FFFF, DATA=FFFF -> leds_o=FFFF steady; rewrite PERIOD=2 -> phase restarts 0.
//  PWM (LEDS_PWM_EN): DUTY=64 -> each LED high 64 of 256 cycles; DUTY=0 -> 0; DUTY=FF -> always on.
//  Read-back/collision: write MODE=1234 while addr_i=1 -> rdata_o old value that cycle, 1234 next.

Source files
------------

// File: rtl/leds_pkg.sv
// Shared definitions for the LED controller: register map, mode encoding,
// reset constants and the per-LED output equation.
package leds_pkg;

    localparam logic [1:0] LED_ADDR_DATA   = 2'd0;
    localparam logic [1:0] LED_ADDR_MODE   = 2'd1;
    localparam logic [1:0] LED_ADDR_PERIOD = 2'd2;
    localparam logic [1:0] LED_ADDR_DUTY   = 2'd3;

    localparam int unsigned LED_DEF_N_LEDS   = 16;
    localparam int unsigned LED_DEF_BLINK_W  = 24;
    localparam int unsigned LED_DEF_PWM_BITS = 8;

    // Phase after reset or a PERIOD write, and the phase held while PERIOD is 0.
    localparam logic LED_PHASE_RST      = 1'b0;
    localparam logic LED_PHASE_NOPERIOD = 1'b1;

    typedef enum logic {
        LED_STATIC = 1'b0,
        LED_BLINK  = 1'b1
    } led_mode_e;

    // Drive level of one LED from its on bit, mode, blink phase and PWM gate.
    function automatic logic led_out_bit(input logic on, input led_mode_e mode,
                                         input logic phase, input logic pwm_on);
        return on & ((mode == LED_BLINK) ? phase : 1'b1) & pwm_on;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Global PWM dimming gate: free-running counter compared against the duty value.
// A duty of all-ones is treated as fully on; a duty of zero is fully off.
module led_pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_on_o
);

    logic [PWM_BITS-1:0] cnt_q;

    // Free-running counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_BITS'(1);
        end
    end

    // Combinational gate; the top registers it together with the LED outputs.
    assign pwm_on_o = (cnt_q < duty_i) | (duty_i == '1);

endmodule

// File: rtl/leds_ctrl_pwm.sv
// Memory-mapped LED peripheral: per-LED on/off, per-LED blink and global PWM dimming.
// Optional feature macro: LEDS_PWM_EN (adds DUTY register and PWM generator).
module leds_ctrl_pwm
    import leds_pkg::*;
#(
    parameter int unsigned N_LEDS   = LED_DEF_N_LEDS,
    parameter int unsigned BLINK_W  = LED_DEF_BLINK_W,
    parameter int unsigned PWM_BITS = LED_DEF_PWM_BITS
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [1:0]        addr_i,
    input  logic              we_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       rdata_o,
    output logic [N_LEDS-1:0] leds_o
);

    logic [N_LEDS-1:0]  data_q;
    logic [N_LEDS-1:0]  mode_q;
    logic [BLINK_W-1:0] period_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_d;
    logic               phase_q;
    logic               phase_d;
    logic               period_wr_c;
    logic               pwm_on_c;
    logic [31:0]        rdata_d;
    logic [N_LEDS-1:0]  leds_d;
    logic               unused_c;

    // Upper write-data bits beyond each register's width are intentionally dropped.
    assign unused_c    = ^{data_i, {PWM_BITS{1'b0}}};
    assign period_wr_c = we_i & (addr_i == LED_ADDR_PERIOD);

    // Register bank writes; reset has priority over a concurrent write.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            data_q   <= '0;
            mode_q   <= '0;
            period_q <= '0;
        end else if (we_i) begin
            case (addr_i)
                LED_ADDR_DATA:   data_q   <= data_i[N_LEDS-1:0];
                LED_ADDR_MODE:   mode_q   <= data_i[N_LEDS-1:0];
                LED_ADDR_PERIOD: period_q <= data_i[BLINK_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef LEDS_PWM_EN
    logic [PWM_BITS-1:0] duty_q;

    // DUTY register, reset to fully on.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            duty_q <= '1;
        end else if (we_i && (addr_i == LED_ADDR_DUTY)) begin
            duty_q <= data_i[PWM_BITS-1:0];
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk_i    (clk_i),
        .rst      (rst),
        .duty_i   (duty_q),
        .pwm_on_o (pwm_on_c)
    );
`else
    assign pwm_on_c = 1'b1;
`endif

    // Blink counter and phase next-state; a PERIOD write restarts the blink cycle.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (period_wr_c) begin
            blink_cnt_d = '0;
            phase_d     = LED_PHASE_RST;
        end else if (period_q == '0) begin
            blink_cnt_d = '0;
            phase_d     = LED_PHASE_NOPERIOD;
        end else if (blink_cnt_q == (period_q - BLINK_W'(1))) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    // Blink state register.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            phase_q     <= LED_PHASE_RST;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Read mux from pre-write register values, so same-address writes read old data.
    always_comb begin
        rdata_d = '0;
        case (addr_i)
            LED_ADDR_DATA:   rdata_d = 32'(data_q);
            LED_ADDR_MODE:   rdata_d = 32'(mode_q);
            LED_ADDR_PERIOD: rdata_d = 32'(period_q);
`ifdef LEDS_PWM_EN
            LED_ADDR_DUTY:   rdata_d = 32'(duty_q);
`endif
            default:         rdata_d = '0;
        endcase
    end

    // Per-LED drive from registers, blink phase and PWM gate.
    always_comb begin
        leds_d = '0;
        for (int i = 0; i < int'(N_LEDS); i++) begin
            leds_d[i] = led_out_bit(data_q[i], led_mode_e'(mode_q[i]), phase_q, pwm_on_c);
        end
    end

    // Output registers for read data and LED pins.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            rdata_o <= '0;
            leds_o  <= '0;
        end else begin
            rdata_o <= rdata_d;
            leds_o  <= leds_d;
        end
    end

endmodule

// File: tb/tb_leds_ctrl_pwm.sv
// Scoreboard bench for leds_ctrl_pwm: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against rdata_o / leds_o.
module tb_leds_ctrl_pwm;

    logic        clk_i = 1'b0;
    logic        rst;
    logic [1:0]  addr_i;
    logic        we_i;
    logic [31:0] data_i;
    logic [31:0] rdata_o;
    logic [15:0] leds_o;

    typedef struct {
        int unsigned cyc;
        bit          is_leds;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          flush    = 1'b0;

    localparam int unsigned WATCHDOG_CYCLES = 5000;

`ifdef LEDS_PWM_EN
    localparam logic [31:0] DUTY_RST_RD = 32'h0000_00FF;
`else
    localparam logic [31:0] DUTY_RST_RD = 32'h0000_0000;
`endif

    leds_ctrl_pwm dut (
        .clk_i   (clk_i),
        .rst     (rst),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .data_i  (data_i),
        .rdata_o (rdata_o),
        .leds_o  (leds_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk_i) begin
        logic [31:0] act;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc || flush) begin
                act = sb[i].is_leds ? 32'(leds_o) : rdata_o;
                n_checks++;
                if (sb[i].cyc == cyc && act === sb[i].exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d (due %0d) got=%h exp=%h",
                             sb[i].name, cyc, sb[i].cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    // Watchdog: the test must finish within a bounded number of cycles.
    initial begin
        repeat (WATCHDOG_CYCLES) @(posedge clk_i);
        $display("FAIL timeout: test did not finish within %0d cycles", WATCHDOG_CYCLES);
        $finish;
    end

    function automatic void sb_push(int unsigned at, bit is_leds, logic [31:0] e, string nm);
        exp_t x;
        x.cyc     = at;
        x.is_leds = is_leds;
        x.exp     = e;
        x.name    = nm;
        sb.push_back(x);
    endfunction

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        step();
        we_i   = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] e, input string nm);
        addr_i = a;
        sb_push(cyc + 1, 1'b0, e, nm);
        step();
    endtask

    initial begin
        logic [31:0] rst_rd [4];
        logic [31:0] e;
        logic [7:0]  pcnt;
        rst_rd = '{32'h0, 32'h0, 32'h0, DUTY_RST_RD};

        // Reset held two edges while writes are attempted.
        rst    = 1'b0;
        we_i   = 1'b1;
        data_i = 32'h0000_FFFF;
        addr_i = 2'd0;
        sb_push(1, 1'b1, 32'h0, "rst_leds1");
        sb_push(2, 1'b1, 32'h0, "rst_leds2");
        sb_push(2, 1'b0, 32'h0, "rst_rdata");
        step();
        addr_i = 2'd2;
        step();
        n_checks++;
        if (leds_o === 16'h0 && rdata_o === 32'h0) begin
            n_pass++;
        end else begin
            $display("FAIL rst_state cyc=%0d leds=%h rdata=%h", cyc, leds_o, rdata_o);
        end
        rst  = 1'b1;
        we_i = 1'b0;
        for (int a = 0; a < 4; a++) begin
            sb_push(cyc + 1, 1'b1, 32'h0, "rst_leds_hold");
            rd_check(2'(a), rst_rd[a], "rst_read");
        end

        // Static on/off.
        wr(2'd0, 32'h0000_A5A5);
        for (int k = 1; k <= 3; k++) sb_push(cyc + k, 1'b1, 32'h0000_A5A5, "static");
        step(); step(); step();

        // Read-during-write to MODE returns old value, new value one cycle later.
        addr_i = 2'd1;
        data_i = 32'h0000_1234;
        we_i   = 1'b1;
        sb_push(cyc + 1, 1'b0, 32'h0, "collide_old");
        step();
        we_i = 1'b0;
        sb_push(cyc + 1, 1'b0, 32'h0000_1234, "collide_new");
        sb_push(cyc + 2, 1'b1, 32'h0000_A5A5, "mode_period0");
        step(); step(); step();

        // Blink with PERIOD=4: bits 1:0 toggle every 4 cycles, bits 3:2 steady.
        wr(2'd0, 32'h0000_000F);
        wr(2'd1, 32'h0000_0003);
        wr(2'd2, 32'h0000_0004);
        for (int k = 0; k < 12; k++) begin
            e = (((k / 4) % 2) == 1) ? 32'h0000_000F : 32'h0000_000C;
            sb_push(cyc + 1 + k, 1'b1, e, "blink4");
        end
        repeat (12) step();

        // PERIOD=0 with everything blinking: steady on.
        wr(2'd2, 32'h0000_0000);
        wr(2'd0, 32'h0000_FFFF);
        wr(2'd1, 32'h0000_FFFF);
        for (int k = 1; k <= 6; k++) sb_push(cyc + k, 1'b1, 32'h0000_FFFF, "period0");
        repeat (6) step();

        // PERIOD=2 (upper data bits dropped): phase restarts at 0.
        wr(2'd2, 32'hFF00_0002);
        for (int k = 0; k < 6; k++) begin
            e = (k == 2 || k == 3) ? 32'h0000_FFFF : 32'h0000_0000;
            sb_push(cyc + 1 + k, 1'b1, e, "period2_restart");
        end
        repeat (6) step();
        rd_check(2'd2, 32'h0000_0002, "period_read");

        // DATA upper bits ignored on write and read back as zero.
        wr(2'd0, 32'h1234_00FF);
        rd_check(2'd0, 32'h0000_00FF, "data_trunc");
        wr(2'd0, 32'h0000_FFFF);
        wr(2'd1, 32'h0000_0000);

`ifdef LEDS_PWM_EN
        // PWM counter cleared on reset edges 1,2, so leds at cycle n use count (n-3).
        wr(2'd3, 32'hFFFF_FF40);
        for (int k = 1; k <= 256; k++) begin
            pcnt = 8'(cyc + k - 3);
            e = (pcnt < 8'h40) ? 32'h0000_FFFF : 32'h0;
            sb_push(cyc + k, 1'b1, e, "pwm64");
        end
        repeat (256) step();
        wr(2'd3, 32'h0000_0000);
        for (int k = 1; k <= 16; k++) sb_push(cyc + k, 1'b1, 32'h0, "pwm0");
        repeat (16) step();
        wr(2'd3, 32'h0000_00FF);
        for (int k = 1; k <= 16; k++) sb_push(cyc + k, 1'b1, 32'h0000_FFFF, "pwmff");
        repeat (16) step();
        rd_check(2'd3, 32'h0000_00FF, "duty_read");
`else
        // Without PWM, DUTY writes are ignored and LEDs stay fully on.
        wr(2'd3, 32'h0000_0000);
        for (int k = 1; k <= 8; k++) sb_push(cyc + k, 1'b1, 32'h0000_FFFF, "nopwm_on");
        repeat (8) step();
        rd_check(2'd3, 32'h0000_0000, "duty_absent");
`endif

        // Drain outstanding expectations; anything left is reported by the monitor.
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        if (sb.size() != 0 || n_pass != n_checks) begin
            $display("FAIL summary: %0d pending, %0d/%0d passed", sb.size(), n_pass, n_checks);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
